// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and address-split helpers for the direct-mapped
// data cache.
//   state_e  - controller states (IDLE lookup, REFILL read-miss fill,
//              WRITE write-through, DONE post-fill lookup)
//   word_w / idx_w / tag_w - field widths derived from the cache geometry
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Byte offset within a 32-bit word.
  localparam int OFF_W = 2;

  // Word-in-line select width; zero when a line holds a single word.
  function automatic int word_w(input int words);
    return (words > 1) ? $clog2(words) : 0;
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int lines, input int words);
    return addr_w - OFF_W - word_w(words) - idx_w(lines);
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// dcache_line_store: valid/tag/data arrays of the direct-mapped cache.
// Ports:
//   clk, reset   - clock, async active-low reset (clears valid bits only)
//   idx          - line index shared by the read and write sides
//   rd_word      - word select for the read port
//   rd_valid/rd_tag/rd_data - combinational read of line idx
//   wr_en/wr_word/wr_be/wr_data - byte-enable write into line idx
//   inv_en       - clear valid of line idx
//   fill_en/fill_tag - install tag and set valid of line idx
module dcache_line_store #(
  parameter int LINES = 16,
  parameter int WORDS = 4,
  parameter int IDX_W = 4,
  parameter int WB    = 2,
  parameter int TAG_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] idx,
  input  logic [WB-1:0]    rd_word,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [WB-1:0]    wr_word,
  input  logic [3:0]       wr_be,
  input  logic [31:0]      wr_data,
  input  logic             inv_en,
  input  logic             fill_en,
  input  logic [TAG_W-1:0] fill_tag
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES][WORDS];

  assign rd_valid = valid_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_data  = data_q[idx][rd_word];

  always_comb begin
    valid_d = valid_q;
    if (inv_en)  valid_d[idx] = 1'b0;
    if (fill_en) valid_d[idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Tag and data storage are not reset; valid gates every use.
  always_ff @(posedge clk) begin
    if (fill_en) tag_q[idx] <= fill_tag;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) data_q[idx][wr_word][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped, write-through, no-write-allocate data cache
// between the core data port and a single-word req/ack memory.
// Ports:
//   clk, reset (async active-low)
//   cpu_addr/cpu_wdata/cpu_read/cpu_write/cpu_byte - core request, held
//     stable until dhit; write wins if read and write are both high
//   cpu_rdata, dhit - aligned read word and access-complete strobe
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be - memory request, stable
//     until mem_ack; mem_rdata/mem_ack - memory response
// Optional (macro DCACHE_STATS_EN): hit_cnt, miss_cnt saturating counters.
module dcache_dm
  import dcache_pkg::*;
#(
  parameter int LINES  = 16,
  parameter int WORDS  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic              cpu_byte,
  output logic [31:0]       cpu_rdata,
  output logic              dhit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int WORD_W = word_w(WORDS);
  localparam int WB     = (WORD_W > 0) ? WORD_W : 1;
  localparam int IDX_W  = idx_w(LINES);
  localparam int TAG_W  = tag_w(ADDR_W, LINES, WORDS);

  state_e            state_q, state_d;
  logic [WB-1:0]     cnt_q, cnt_d;

  logic [1:0]        cpu_off;
  logic [WB-1:0]     cpu_word;
  logic [IDX_W-1:0]  cpu_idx;
  logic [TAG_W-1:0]  cpu_tag;
  logic [ADDR_W-1:0] refill_addr, word_addr;

  logic              rd_valid, hit;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       rd_data;

  logic              st_wr_en, inv_en, fill_en;
  logic [WB-1:0]     st_word;
  logic [3:0]        st_be;
  logic [31:0]       st_data;
  logic [31:0]       wr_wdata;
  logic [3:0]        wr_be;

  // Address split: tag | index | word | byte offset.
  assign cpu_off = cpu_addr[1:0];
  assign cpu_idx = cpu_addr[OFF_W+WORD_W +: IDX_W];
  assign cpu_tag = cpu_addr[ADDR_W-1 -: TAG_W];
  assign word_addr = {cpu_addr[ADDR_W-1:OFF_W], 2'b00};

  if (WORD_W > 0) begin : g_word
    assign cpu_word    = cpu_addr[OFF_W +: WB];
    assign refill_addr = {cpu_tag, cpu_idx, cnt_q, 2'b00};
  end else begin : g_noword
    assign cpu_word    = '0;
    assign refill_addr = {cpu_tag, cpu_idx, 2'b00};
  end

  assign hit = rd_valid && (rd_tag == cpu_tag);

  // Byte stores replicate the byte on every lane; the enable picks the lane.
  always_comb begin
    if (cpu_byte) begin
      wr_wdata = {4{cpu_wdata[7:0]}};
      wr_be    = 4'b0001 << cpu_off;
    end else begin
      wr_wdata = cpu_wdata;
      wr_be    = 4'hF;
    end
  end

  dcache_line_store #(
    .LINES(LINES), .WORDS(WORDS), .IDX_W(IDX_W), .WB(WB), .TAG_W(TAG_W)
  ) u_store (
    .clk      (clk),
    .reset    (reset),
    .idx      (cpu_idx),
    .rd_word  (cpu_word),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (st_wr_en),
    .wr_word  (st_word),
    .wr_be    (st_be),
    .wr_data  (st_data),
    .inv_en   (inv_en),
    .fill_en  (fill_en),
    .fill_tag (cpu_tag)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dhit      = 1'b0;
    cpu_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    st_wr_en  = 1'b0;
    st_word   = cpu_word;
    st_be     = wr_be;
    st_data   = wr_wdata;
    inv_en    = 1'b0;
    fill_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_write) begin
          state_d = WRITE;
        end else if (cpu_read) begin
          if (hit) begin
            dhit      = 1'b1;
            cpu_rdata = rd_data;
          end else begin
            // Line is invalid while it is being overwritten.
            state_d = REFILL;
            cnt_d   = '0;
            inv_en  = 1'b1;
          end
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_be   = 4'hF;
        mem_addr = refill_addr;
        st_word  = cnt_q;
        st_be    = 4'hF;
        st_data  = mem_rdata;
        if (mem_ack) begin
          st_wr_en = 1'b1;
          if (cnt_q == WB'(WORDS - 1)) begin
            fill_en = 1'b1;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = word_addr;
        mem_wdata = wr_wdata;
        mem_be    = wr_be;
        if (mem_ack) begin
          dhit     = 1'b1;
          // Hit is re-evaluated here; a miss never allocates.
          st_wr_en = hit;
          state_d  = IDLE;
        end
      end
      DONE: begin
        dhit      = 1'b1;
        cpu_rdata = rd_data;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        hit_evt, miss_evt;
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // A read hit completes in its single IDLE cycle, so each counts once.
  assign hit_evt  = (state_q == IDLE) && !cpu_write && cpu_read && hit;
  assign miss_evt = (state_q == IDLE) && !cpu_write && cpu_read && !hit;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_evt  && (hit_cnt_q  != '1)) hit_cnt_d  = hit_cnt_q  + 32'd1;
    if (miss_evt && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_dm.sv
// tb_dcache_dm: directed, table-driven bench for dcache_dm (defaults
// LINES=16, WORDS=4, ADDR_W=32) with a 2-cycle-ack word memory model.
module tb_dcache_dm;

  localparam int LAT = 2;

  logic        clk;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_read, cpu_write, cpu_byte, dhit;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack   = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  dcache_dm dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_byte  (cpu_byte),
    .cpu_rdata (cpu_rdata),
    .dhit      (dhit),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } tx_t;

  logic [31:0] mem [logic [31:0]];
  tx_t         txq[$];
  int          wcnt = 0;

  function automatic logic [31:0] mrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  always begin
    @(negedge clk);
    if (mem_ack) begin
      mem_ack = 1'b0;
      wcnt    = mem_req ? 1 : 0;
    end else if (mem_req) begin
      wcnt++;
      if (wcnt >= LAT) begin
        logic [31:0] m;
        mem_ack = 1'b1;
        txq.push_back('{mem_addr, mem_we, mem_be, mem_wdata});
        if (mem_we) begin
          m = mrd(mem_addr);
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) m[8*b +: 8] = mem_wdata[8*b +: 8];
          mem[mem_addr] = m;
        end else begin
          mem_rdata = mrd(mem_addr);
        end
      end
    end else begin
      wcnt = 0;
    end
  end

  // Memory-side outputs must hold while a request waits for its ack.
  logic        pv = 1'b0, p_req, p_ack, p_we;
  logic [31:0] p_addr, p_wd;
  logic [3:0]  p_be;
  always begin
    @(negedge clk);
    #2;
    if (!reset) begin
      pv = 1'b0;
    end else begin
      if (pv && p_req && !p_ack) begin
        checks++;
        if (!mem_req || mem_addr !== p_addr || mem_we !== p_we ||
            mem_be !== p_be || mem_wdata !== p_wd) begin
          errors++;
          $display("FAIL mem_stable got req=%b addr=%h want req=1 addr=%h",
                   mem_req, mem_addr, p_addr);
        end
      end
      pv = 1'b1; p_req = mem_req; p_ack = mem_ack; p_we = mem_we;
      p_addr = mem_addr; p_wd = mem_wdata; p_be = mem_be;
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd, wr, byt;
    logic [31:0] exp_rdata;
    int          exp_cyc;
    int          exp_ntx;
    logic [31:0] exp_first, exp_last;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
  } vec_t;

  function automatic vec_t mk(
    input logic [31:0] addr, input logic [31:0] wdata,
    input logic rd, input logic wr, input logic byt,
    input logic [31:0] exp_rdata, input int cyc, input int ntx,
    input logic [31:0] first, input logic [31:0] last,
    input logic [3:0] be, input logic [31:0] wd);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.rd = rd; v.wr = wr; v.byt = byt;
    v.exp_rdata = exp_rdata; v.exp_cyc = cyc; v.exp_ntx = ntx;
    v.exp_first = first; v.exp_last = last; v.exp_be = be; v.exp_wd = wd;
    return v;
  endfunction

  int exp_hit = 0, exp_miss = 0;

  task automatic do_vec(input string id, input vec_t v);
    int          cyc;
    logic        got;
    logic [31:0] rdat;
    cyc = 0; got = 1'b0; rdat = '0;
    @(posedge clk); #1;
    txq.delete();
    cpu_addr = v.addr; cpu_wdata = v.wdata;
    cpu_read = v.rd; cpu_write = v.wr; cpu_byte = v.byt;
    while (!got && cyc < 60) begin
      @(negedge clk); #1;
      cyc++;
      if (dhit) begin got = 1'b1; rdat = cpu_rdata; end
    end
    if (!got) begin
      errors++; checks++;
      $display("FAIL %s_timeout got=no_dhit want=dhit", id);
    end
    @(posedge clk); #1;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_byte = 1'b0;
    chk({id, "_cyc"}, 32'(cyc), 32'(v.exp_cyc));
    if (v.rd && !v.wr) begin
      chk({id, "_rdata"}, rdat, v.exp_rdata);
      if (v.exp_cyc == 1) exp_hit++; else exp_miss++;
    end
    chk({id, "_ntx"}, 32'(txq.size()), 32'(v.exp_ntx));
    if (v.exp_ntx > 0 && txq.size() > 0) begin
      chk({id, "_first"}, txq[0].addr, v.exp_first);
      chk({id, "_last"}, txq[txq.size()-1].addr, v.exp_last);
      chk({id, "_we"}, 32'(txq[0].we), 32'(v.wr));
      chk({id, "_be"}, 32'(txq[0].be), 32'(v.exp_be));
      if (v.wr) chk({id, "_wd"}, txq[0].wdata, v.exp_wd);
    end
  endtask

  task automatic chk_idle(input string id);
    chk({id, "_dhit"},  32'(dhit),    32'd0);
    chk({id, "_req"},   32'(mem_req), 32'd0);
    chk({id, "_we"},    32'(mem_we),  32'd0);
    chk({id, "_be"},    32'(mem_be),  32'd0);
    chk({id, "_addr"},  mem_addr,     32'd0);
    chk({id, "_rdata"}, cpu_rdata,    32'd0);
  endtask

  vec_t vt[$];
  vec_t vp[$];

  initial begin
    reset = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_byte = 1'b0;
    mem[32'h40]  = 32'h11; mem[32'h44]  = 32'h22;
    mem[32'h48]  = 32'h33; mem[32'h4C]  = 32'h44;
    mem[32'h140] = 32'h55; mem[32'h144] = 32'h66;
    mem[32'h148] = 32'h77; mem[32'h14C] = 32'h88;

    //        addr          wdata         rd wr by exp_rdata    cyc ntx first         last          be    wd
    vt.push_back(mk(32'h40,       0,            1, 0, 0, 32'h11,       10, 4, 32'h40,       32'h4C,       4'hF, 0));
    vt.push_back(mk(32'h48,       0,            1, 0, 0, 32'h33,       1,  0, 0,            0,            4'hF, 0));
    vt.push_back(mk(32'h4C,       0,            1, 0, 0, 32'h44,       1,  0, 0,            0,            4'hF, 0));
    vt.push_back(mk(32'h41,       32'hAB,       0, 1, 1, 0,            3,  1, 32'h40,       32'h40,       4'h2, 32'hABABABAB));
    vt.push_back(mk(32'h40,       0,            1, 0, 0, 32'h0000AB11, 1,  0, 0,            0,            4'hF, 0));
    vt.push_back(mk(32'h140,      0,            1, 0, 0, 32'h55,       10, 4, 32'h140,      32'h14C,      4'hF, 0));
    vt.push_back(mk(32'h40,       0,            1, 0, 0, 32'h0000AB11, 10, 4, 32'h40,       32'h4C,       4'hF, 0));
    vt.push_back(mk(32'h800,      32'hDEADBEEF, 0, 1, 0, 0,            3,  1, 32'h800,      32'h800,      4'hF, 32'hDEADBEEF));
    vt.push_back(mk(32'h800,      0,            1, 0, 0, 32'hDEADBEEF, 10, 4, 32'h800,      32'h80C,      4'hF, 0));
    vt.push_back(mk(32'h804,      0,            1, 0, 0, 32'hA5A50804, 1,  0, 0,            0,            4'hF, 0));
    vt.push_back(mk(32'h48,       32'h12345678, 1, 1, 0, 0,            3,  1, 32'h48,       32'h48,       4'hF, 32'h12345678));
    vt.push_back(mk(32'h48,       0,            1, 0, 0, 32'h12345678, 1,  0, 0,            0,            4'hF, 0));
    vt.push_back(mk(32'h3F0,      0,            1, 0, 0, 32'hA5A503F0, 10, 4, 32'h3F0,      32'h3FC,      4'hF, 0));
    vt.push_back(mk(32'h3F3,      32'hCD,       0, 1, 1, 0,            3,  1, 32'h3F0,      32'h3F0,      4'h8, 32'hCDCDCDCD));
    vt.push_back(mk(32'h3F0,      0,            1, 0, 0, 32'hCDA503F0, 1,  0, 0,            0,            4'hF, 0));
    vt.push_back(mk(32'h80000044, 0,            1, 0, 0, 32'h25A50044, 10, 4, 32'h80000040, 32'h8000004C, 4'hF, 0));
    vt.push_back(mk(32'h40,       0,            1, 0, 0, 32'h0000AB11, 10, 4, 32'h40,       32'h4C,       4'hF, 0));

    // Post-reset sequence: 1 miss, 3 hits, 1 miss, 1 write.
    vp.push_back(mk(32'h40,       0,            1, 0, 0, 32'h0000AB11, 10, 4, 32'h40,       32'h4C,       4'hF, 0));
    vp.push_back(mk(32'h44,       0,            1, 0, 0, 32'h22,       1,  0, 0,            0,            4'hF, 0));
    vp.push_back(mk(32'h48,       0,            1, 0, 0, 32'h12345678, 1,  0, 0,            0,            4'hF, 0));
    vp.push_back(mk(32'h4C,       0,            1, 0, 0, 32'h44,       1,  0, 0,            0,            4'hF, 0));
    vp.push_back(mk(32'h140,      0,            1, 0, 0, 32'h55,       10, 4, 32'h140,      32'h14C,      4'hF, 0));
    vp.push_back(mk(32'h200,      32'h77,       0, 1, 0, 0,            3,  1, 32'h200,      32'h200,      4'hF, 32'h00000077));

    // Reset state, including a read request held during reset.
    repeat (3) @(posedge clk);
    #1;
    chk_idle("rst");
    cpu_read = 1'b1; cpu_addr = 32'h40;
    #1;
    chk_idle("rst_rd");
    cpu_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    foreach (vt[k]) do_vec($sformatf("v%0d", k), vt[k]);

    // Reset mid-refill: outputs drop at once, line left invalid.
    begin
      int n;
      n = 0;
      @(posedge clk); #1;
      txq.delete();
      cpu_addr = 32'h140; cpu_read = 1'b1;
      while (txq.size() < 2 && n < 40) begin
        @(negedge clk); #1;
        n++;
      end
      chk("midrst_acks", 32'(txq.size()), 32'd2);
      reset = 1'b0;
      #1;
      chk("midrst_req",  32'(mem_req), 32'd0);
      chk("midrst_dhit", 32'(dhit),    32'd0);
      cpu_read = 1'b0;
      exp_hit = 0; exp_miss = 0;
      @(posedge clk); #1;
      reset = 1'b1;
      chk_idle("postrst");
    end

    foreach (vp[k]) do_vec($sformatf("p%0d", k), vp[k]);

`ifdef DCACHE_STATS_EN
    chk("hit_cnt",  hit_cnt,  32'(exp_hit));
    chk("miss_cnt", miss_cnt, 32'(exp_miss));
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_dm.md
Name: dcache_dm

Overview:
- Parametrised direct-mapped data cache between the multicycle RISC-V core's data port and main memory.
- Generates the core's `dhit` stall/ready signal.
- Write-through, no-write-allocate policy; line refill on read miss over a single-word req/ack memory handshake.
- Generalises the fixed single-cycle data port to configurable line count and line size, with byte-store support.

Parameters:
- LINES, 16, number of cache lines (power of two, ≥2)
- WORDS, 4, 32-bit words per line (power of two, ≥1)
- ADDR_W, 32, byte address width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_addr  in  ADDR_W  byte address from core (ALUOut)
- cpu_wdata  in  32  store data (WriteData)
- cpu_read  in  1  load request, held until dhit
- cpu_write  in  1  store request, held until dhit
- cpu_byte  in  1  byte access (lane = cpu_addr[1:0])
- cpu_rdata  out  32  full aligned word to core (ReadData)
- dhit  out  1  access complete this cycle
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  word-aligned memory address
- mem_wdata  out  32  memory write data
- mem_be  out  4  byte enables
- mem_rdata  in  32  memory read data
- mem_ack  in  1  one word transferred this cycle

Behaviour:
- Address split: off = addr[1:0]; word = next log2(WORDS) bits; index = next log2(LINES) bits; tag = remainder.
- Reset (async, active-low): all valid bits 0, FSM IDLE, refill counter 0, all outputs 0. Data/tag arrays are not reset.
- FSM states:
  - IDLE: lookup.
  - REFILL: read miss fill.
  - WRITE: write-through.
  - DONE: one-cycle lookup after fill.
- Request priority: cpu_write has priority if both requests are high; the read is ignored that cycle.
- Read hit: IDLE, valid[index] and tag match → dhit=1 combinationally, same cycle; cpu_rdata = line word. Zero-cycle latency.
- Read miss: dhit=0; next state REFILL.
  - Refill issues mem_req=1, mem_we=0, mem_be=4'hF, mem_addr = {tag,index,cnt,2'b00}, with cnt from 0 to WORDS-1.
  - Each mem_ack writes the word into the line and increments cnt.
  - Ack with cnt=WORDS-1: set tag and valid, go to DONE; mem_req drops that same edge.
  - DONE: dhit=1 with the refilled word, then back to IDLE.
  - Miss latency = WORDS acks + 2 cycles.
- Write (hit or miss): IDLE → WRITE.
  - WRITE drives mem_req=1, mem_we=1, mem_addr = word-aligned cpu_addr.
  - Word store: mem_wdata = cpu_wdata, mem_be = 4'hF.
  - Byte store: mem_wdata = cpu_wdata[7:0] replicated to all four lanes, mem_be = one-hot(off).
  - On mem_ack: dhit=1 that cycle. If hit (tag re-checked at ack), merge enabled bytes into the line; miss does not allocate. Return to IDLE.
- The core must hold address, data and request stable until dhit. mem_* outputs stay stable while mem_req=1 and mem_ack=0.
- mem_ack while not requesting is ignored.
- No request in IDLE: dhit=0, mem_req=0.
- Index wrap: index and word counter wrap modulo LINES/WORDS; no overflow into tag.
- Reset mid-refill or mid-write: abandon immediately. Line stays invalid; memory sees mem_req drop asynchronously.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined: adds 32-bit outputs hit_cnt and miss_cnt.
  - Read hit in IDLE increments hit_cnt once per request (not per stalled cycle).
  - Read miss entering REFILL increments miss_cnt.
  - Writes are not counted.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package dcache_pkg: FSM state enum (IDLE, REFILL, WRITE, DONE) and localparam helpers for OFF_W, WORD_W, IDX_W, TAG_W derived from parameters.
- One sub-module, dcache_line_store: valid/tag/data arrays with a read port and a byte-enable write port.
- FSM and address/byte-lane muxing stay in dcache_dm.

Test Plan (defaults LINES=16, WORDS=4, memory ack latency 2 cycles):
- Cold read 0x0000_0040: memory returns 0x11,0x22,0x33,0x44 for 0x40,0x44,0x48,0x4C → four mem_req reads in order, then DONE with dhit=1, cpu_rdata=0x11. Next read 0x0000_0048 hits same cycle with 0x33.
- Conflict: after the line above, read 0x0000_0140 (same index 4, tag 1) → miss and refill. Re-read 0x40 → miss again.
- Byte store 0xAB at 0x0000_0041 while resident → mem_be=4'b0010, mem_wdata=0xABABABAB. After ack, read 0x40 returns 0x0000AB11 with no memory request.
- Word store 0xDEADBEEF to non-resident 0x0000_0800 → one memory write, dhit on ack. Subsequent read 0x800 misses (no allocate).
- Reset low mid-refill after 2 acks → mem_req=0 and dhit=0 immediately. After release, read 0x40 performs a full 4-word refill.
- With DCACHE_STATS_EN: 3 read hits, 2 read misses, 1 write → hit_cnt=3, miss_cnt=2.
